// File: rtl/fetch_pkg.sv
// Shared constants, entry layout and helpers for the instruction-fetch front end.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Default-width layout of a fetch buffer entry; the top rebuilds it at XLEN/ILEN.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush empties it and takes priority over push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  FIFO_DEPTH = 2,
    parameter type entry_t    = fetch_entry_t
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  entry_t                      push_data,
    input  logic                        pop,
    input  logic                        flush,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output entry_t                      head,
    output logic                        empty,
    output logic                        full
);

    localparam int AW = $clog2(FIFO_DEPTH);

    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone decide which words are valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr_q] <= push_data;
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, credit-based imem issue, tagged fetch buffer, redirect/flush.
// Optional perf counters (perf_fetched/perf_flushed) are built when FETCH_PERF_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               XLEN       = 32,
    parameter int               ILEN       = 32,
    parameter int               IMEM_DEPTH = 256,
    parameter int               FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0]  RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          imem_req,
    output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
    input  logic [ILEN-1:0]               imem_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ILEN-1:0]               out_instr,
    output logic [XLEN-1:0]               out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]                   perf_fetched,
    output logic [31:0]                   perf_flushed
`endif
);

    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tag_q, tag_d;
    logic            inflight_q, inflight_d;

    logic [CW-1:0]   count;
    logic [CW:0]     credit;
    logic            empty, full;
    logic            pop, push, issue;
    entry_t          head, push_entry;

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        out_valid  = ~empty & ~rst;
        pop        = out_valid & out_ready;
        // Entries held plus the one in flight, minus the one leaving, must leave room for a new word.
        credit     = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        issue      = ~rst & ~redirect_valid & (credit < (CW+1)'(FIFO_DEPTH));
        push       = inflight_q & ~redirect_valid & ~rst & (~full | pop);

        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = 1'b0;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~XLEN'(3);
        end else if (issue) begin
            pc_d       = pc_q + XLEN'(4);
            tag_d      = pc_q;
            inflight_d = 1'b1;
        end

        push_entry.pc    = tag_q;
        push_entry.instr = imem_rdata;

        imem_req  = issue;
        imem_addr = pc_q[AW+1:2];
        out_instr = out_valid ? head.instr : ILEN'(NOP_INSTR);
        out_pc    = out_valid ? head.pc : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .entry_t    (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .head      (head),
        .empty     (empty),
        .full      (full)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;
    logic [31:0] flushed_now;

    // A pop in the redirect cycle still completes, so it is not counted as discarded.
    assign flushed_now = 32'(count) - 32'(pop) + 32'(inflight_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= sat_add32(perf_fetched_q, 32'(pop));
            if (redirect_valid) perf_flushed_q <= sat_add32(perf_flushed_q, flushed_now);
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected PC streams are loaded on reset/redirect and checked on every pop.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
    logic [31:0] flushed_before;
`endif

    int          n_cmp  = 0;
    int          n_err  = 0;
    int          n_pops = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN       (32),
        .ILEN       (32),
        .IMEM_DEPTH (256),
        .FIFO_DEPTH (2),
        .RESET_PC   (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    // Synchronous-read memory: word index times 0x10.
    always @(posedge clk) imem_rdata <= 32'(imem_addr) << 4;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        return {20'h0, pc[9:2], 4'h0};
    endfunction

    function automatic void reload(input logic [31:0] base);
        sb_q.delete();
        for (int i = 0; i < 64; i++) sb_q.push_back(base + 32'(4 * i));
    endfunction

    // Monitor: compare every accepted head against the scoreboard, then apply this cycle's flush events.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (out_ready === 1'b1) begin
                n_pops++;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_pop", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [31:0] exp_pc;
                    exp_pc = sb_q.pop_front();
                    check("sb_pc", 64'(out_pc), 64'(exp_pc));
                    check("sb_instr", 64'(out_instr), 64'(exp_instr(exp_pc)));
                end
            end
        end else begin
            check("idle_instr", 64'(out_instr), 64'(NOP));
            check("idle_pc", 64'(out_pc), 64'h0);
        end
        if (rst === 1'b1) begin
            reload(32'h0);
            n_pops = 0;
        end else if (redirect_valid === 1'b1) begin
            reload(redirect_pc & ~32'h3);
        end
    end

    task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

        // Reset state
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        check("rst_req", 64'(imem_req), 0);
        check("rst_valid", 64'(out_valid), 0);
        check("rst_instr", 64'(out_instr), 64'(NOP));
        check("rst_pc", 64'(out_pc), 0);
`ifdef FETCH_PERF_EN
        check("rst_perf_fetched", 64'(perf_fetched), 0);
        check("rst_perf_flushed", 64'(perf_flushed), 0);
`endif

        // Reset release, streaming
        cyc(0, 0, 0, 1);
        check("c0_valid", 64'(out_valid), 0);
        check("c0_req", 64'(imem_req), 1);
        check("c0_addr", 64'(imem_addr), 0);
        cyc(0, 0, 0, 1);
        check("c1_valid", 64'(out_valid), 0);
        check("c1_addr", 64'(imem_addr), 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1);
            check("stream_valid", 64'(out_valid), 1);
            check("stream_pc", 64'(out_pc), 64'(32'(4 * i)));
            check("stream_instr", 64'(out_instr), 64'(32'(16 * i)));
        end

        // Backpressure
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0);
            check("bp_valid", 64'(out_valid), 1);
            check("bp_hold_pc", 64'(out_pc), 0);
            check("bp_hold_instr", 64'(out_instr), 0);
            check("bp_no_req", 64'(imem_req), 0);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1);
            check("bp_release_pc", 64'(out_pc), 64'(32'(4 * i)));
        end

        // Redirect during streaming (one entry held, one in flight)
        cyc(1, 0, 0, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1);
`ifdef FETCH_PERF_EN
        flushed_before = perf_flushed;
`endif
        cyc(0, 1, 32'h103, 1);
        check("rd_pop_pc", 64'(out_pc), 64'h10);
        check("rd_no_req", 64'(imem_req), 0);
        cyc(0, 0, 0, 1);
        check("rd_n1_valid", 64'(out_valid), 0);
        check("rd_n1_req", 64'(imem_req), 1);
        check("rd_n1_addr", 64'(imem_addr), 64'h40);
`ifdef FETCH_PERF_EN
        check("rd_perf_flushed", 64'(perf_flushed), 64'(flushed_before + 32'd1));
`endif
        cyc(0, 0, 0, 1);
        check("rd_n2_valid", 64'(out_valid), 0);
        cyc(0, 0, 0, 1);
        check("rd_n3_pc", 64'(out_pc), 64'h100);
        cyc(0, 0, 0, 1);
        check("rd_n4_pc", 64'(out_pc), 64'h104);

        // Redirect with FIFO full and a pop accepted
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        check("full_no_req", 64'(imem_req), 0);
`ifdef FETCH_PERF_EN
        flushed_before = perf_flushed;
`endif
        cyc(0, 1, 32'h200, 1);
        check("full_pop_pc", 64'(out_pc), 0);
        cyc(0, 0, 0, 1);
        check("full_flushed_empty", 64'(out_valid), 0);
`ifdef FETCH_PERF_EN
        check("full_perf_flushed", 64'(perf_flushed), 64'(flushed_before + 32'd1));
`endif
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check("full_target_pc", 64'(out_pc), 64'h200);

        // Address wrap via redirect to 0x3F8
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 32'h3F8, 1);
        cyc(0, 0, 0, 1);
        check("wrap_addr0", 64'(imem_addr), 254);
        cyc(0, 0, 0, 1);
        check("wrap_addr1", 64'(imem_addr), 255);
        cyc(0, 0, 0, 1);
        check("wrap_addr2", 64'(imem_addr), 0);
        check("wrap_pc0", 64'(out_pc), 64'h3F8);
        cyc(0, 0, 0, 1);
        check("wrap_pc1", 64'(out_pc), 64'h3FC);
        cyc(0, 0, 0, 1);
        check("wrap_pc2", 64'(out_pc), 64'h400);
        check("wrap_instr2", 64'(out_instr), 0);

        // Mid-stream reset
        cyc(1, 0, 0, 1);
        check("mrst_valid", 64'(out_valid), 0);
        check("mrst_req", 64'(imem_req), 0);
        cyc(0, 0, 0, 1);
        check("mrst_c0_valid", 64'(out_valid), 0);
        check("mrst_c0_instr", 64'(out_instr), 64'(NOP));
        cyc(0, 0, 0, 1);
        check("mrst_c1_valid", 64'(out_valid), 0);
        cyc(0, 0, 0, 1);
        check("mrst_c2_valid", 64'(out_valid), 1);
        check("mrst_c2_pc", 64'(out_pc), 0);

        // Random backpressure, checked by the scoreboard
        for (int i = 0; i < 40; i++) cyc(0, 0, 0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
`ifdef FETCH_PERF_EN
        check("perf_fetched", 64'(perf_fetched), 64'(n_pops));
`endif
        check("rand_made_progress", 64'(n_pops > 10), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
